wb_arbiter: RTL and testbench

- Write-side producer for the register file. It owns the regfile write port (WE3/AD3/WD3) and merges two result sources:
  - the in-order pipeline writeback (port A, no backpressure);
  - a long-latency multiply/divide unit (port B, valid/ready, buffered in a small FIFO).
- It also keeps a scoreboard of destination registers with outstanding port-B results. Decode uses it to stall dependent reads.

---
 rtl/wb_arbiter.sv | 156 +++++++++++++++
 tb/tb_wb_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Register-file write port owner: merges in-order writeback (port A) with buffered
// MDU results (port B) and tracks destinations with outstanding MDU results.
module wb_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned FIFO_DEPTH    = 2,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wbA_valid_i,
  input  logic [ADDRESS_WIDTH-1:0] wbA_rd_i,
  input  logic [DATA_WIDTH-1:0]    wbA_data_i,
  input  logic                     mdu_valid_i,
  output logic                     mdu_ready_o,
  input  logic [ADDRESS_WIDTH-1:0] mdu_rd_i,
  input  logic [DATA_WIDTH-1:0]    mdu_data_i,
  input  logic                     issue_valid_i,
  input  logic [ADDRESS_WIDTH-1:0] issue_rd_i,
  input  logic [ADDRESS_WIDTH-1:0] rs1_i,
  input  logic [ADDRESS_WIDTH-1:0] rs2_i,
  input  logic [ADDRESS_WIDTH-1:0] rd_chk_i,
  output logic                     hazard_o,
  output logic                     stall_o,
  output logic                     WE3_o,
  output logic [ADDRESS_WIDTH-1:0] AD3_o,
  output logic [DATA_WIDTH-1:0]    WD3_o
);

  localparam int unsigned NREG = 1 << ADDRESS_WIDTH;
  localparam int unsigned IW   = $clog2(FIFO_DEPTH);
  localparam int unsigned PW   = IW + 1;
  localparam int unsigned CW   = $clog2(STARVE_LIMIT + 1);

  logic [ADDRESS_WIDTH-1:0] r_fifo_rd   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0]            r_wr_ptr;
  logic [PW-1:0]            r_rd_ptr;
  logic [CW-1:0]            r_starve;
  logic                     r_stall;
  logic                     r_we;
  logic                     r_src_b;
  logic [ADDRESS_WIDTH-1:0] r_ad;
  logic [DATA_WIDTH-1:0]    r_wd;
  logic [NREG-1:0]          r_pending;

  logic                     w_empty;
  logic                     w_full;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_sel_a;
  logic [ADDRESS_WIDTH-1:0] w_head_rd;
  logic [DATA_WIDTH-1:0]    w_head_data;
  logic [CW-1:0]            w_starve_nxt;
  logic                     w_stall_nxt;
  logic                     w_we_nxt;
  logic                     w_src_b_nxt;
  logic [ADDRESS_WIDTH-1:0] w_ad_nxt;
  logic [DATA_WIDTH-1:0]    w_wd_nxt;
  logic [NREG-1:0]          w_pend_nxt;

  // FIFO status from registered pointers only, so a same-cycle pop never frees a slot
  assign w_empty     = (r_rd_ptr == r_wr_ptr);
  assign w_full      = (r_rd_ptr[PW-1] != r_wr_ptr[PW-1]) &&
                       (r_rd_ptr[IW-1:0] == r_wr_ptr[IW-1:0]);
  assign w_push      = mdu_valid_i && !w_full;
  assign w_head_rd   = r_fifo_rd[r_rd_ptr[IW-1:0]];
  assign w_head_data = r_fifo_data[r_rd_ptr[IW-1:0]];

  // A stalled pipeline forces the FIFO head out; otherwise port A has priority
  assign w_pop   = !w_empty && (r_stall || !wbA_valid_i);
  assign w_sel_a = wbA_valid_i && !w_pop;

  assign mdu_ready_o = !w_full;
  assign hazard_o    = r_pending[rs1_i] | r_pending[rs2_i] | r_pending[rd_chk_i];
  assign stall_o     = r_stall;
  assign WE3_o       = r_we;
  assign AD3_o       = r_ad;
  assign WD3_o       = r_wd;

  always_comb begin
    w_we_nxt    = 1'b0;
    w_src_b_nxt = 1'b0;
    w_ad_nxt    = r_ad;
    w_wd_nxt    = r_wd;
    if (w_pop) begin
      w_we_nxt    = (w_head_rd != '0);
      w_src_b_nxt = 1'b1;
      w_ad_nxt    = w_head_rd;
      w_wd_nxt    = w_head_data;
    end else if (w_sel_a) begin
      w_we_nxt    = (wbA_rd_i != '0);
      w_ad_nxt    = wbA_rd_i;
      w_wd_nxt    = wbA_data_i;
    end
  end

  // Starve counter saturates at the limit; stall follows the next-state count
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_pop) begin
      w_starve_nxt = '0;
    end else if (!w_empty && w_sel_a && (r_starve < CW'(STARVE_LIMIT))) begin
      w_starve_nxt = r_starve + CW'(1);
    end
    w_stall_nxt = (w_starve_nxt >= CW'(STARVE_LIMIT));
  end

  // Clear follows the regfile commit of a port-B result; a same-edge issue wins
  always_comb begin
    w_pend_nxt = r_pending;
    if (r_we && r_src_b) begin
      w_pend_nxt[r_ad] = 1'b0;
    end
    if (issue_valid_i && (issue_rd_i != '0)) begin
      w_pend_nxt[issue_rd_i] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wr_ptr[IW-1:0]]   <= mdu_rd_i;
      r_fifo_data[r_wr_ptr[IW-1:0]] <= mdu_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_starve  <= '0;
      r_stall   <= 1'b0;
      r_we      <= 1'b0;
      r_src_b   <= 1'b0;
      r_ad      <= '0;
      r_wd      <= '0;
      r_pending <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_starve  <= w_starve_nxt;
      r_stall   <= w_stall_nxt;
      r_we      <= w_we_nxt;
      r_src_b   <= w_src_b_nxt;
      r_ad      <= w_ad_nxt;
      r_wd      <= w_wd_nxt;
      r_pending <= w_pend_nxt;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter: a queue-based reference model predicts
// regfile writes and status; a separate monitor compares every cycle.
module tb_wb_arbiter;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wbA_valid_i = 1'b0;
  logic [AW-1:0] wbA_rd_i = '0;
  logic [DW-1:0] wbA_data_i = '0;
  logic          mdu_valid_i = 1'b0;
  logic          mdu_ready_o;
  logic [AW-1:0] mdu_rd_i = '0;
  logic [DW-1:0] mdu_data_i = '0;
  logic          issue_valid_i = 1'b0;
  logic [AW-1:0] issue_rd_i = '0;
  logic [AW-1:0] rs1_i = '0;
  logic [AW-1:0] rs2_i = '0;
  logic [AW-1:0] rd_chk_i = '0;
  logic          hazard_o;
  logic          stall_o;
  logic          WE3_o;
  logic [AW-1:0] AD3_o;
  logic [DW-1:0] WD3_o;

  wb_arbiter #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wbA_valid_i(wbA_valid_i), .wbA_rd_i(wbA_rd_i), .wbA_data_i(wbA_data_i),
    .mdu_valid_i(mdu_valid_i), .mdu_ready_o(mdu_ready_o),
    .mdu_rd_i(mdu_rd_i), .mdu_data_i(mdu_data_i),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_chk_i(rd_chk_i),
    .hazard_o(hazard_o), .stall_o(stall_o),
    .WE3_o(WE3_o), .AD3_o(AD3_o), .WD3_o(WD3_o)
  );

  always #5 clk = ~clk;

  typedef struct { int stamp; logic [AW-1:0] rd; logic [DW-1:0] d; } wr_t;
  typedef struct { logic [AW-1:0] rd; logic [DW-1:0] d; } ent_t;

  wr_t              expq[$];
  ent_t             mq[$];
  int               cyc = 0;
  int               total = 0;
  int               bad = 0;
  int               lost = 0;
  bit               m_stall = 1'b0;
  bit               m_ready = 1'b1;
  bit               m_clr_v = 1'b0;
  logic [AW-1:0]    m_clr = '0;
  bit [(1<<AW)-1:0] m_pend = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: evaluates the cycle that ends at this edge
  always @(posedge clk) begin
    bit   acc;
    bit   nonempty;
    ent_t e;
    cyc++;
    if (!rst_n) begin
      expq.delete();
      mq.delete();
      lost    = 0;
      m_stall = 1'b0;
      m_ready = 1'b1;
      m_clr_v = 1'b0;
      m_pend  = '0;
    end else begin
      acc      = mdu_valid_i && (mq.size() < DEPTH);
      nonempty = mq.size() > 0;
      if (m_clr_v) m_pend[m_clr] = 1'b0;
      m_clr_v = 1'b0;
      if (issue_valid_i && issue_rd_i != '0) m_pend[issue_rd_i] = 1'b1;
      if (nonempty && (m_stall || !wbA_valid_i)) begin
        e    = mq.pop_front();
        lost = 0;
        if (e.rd != '0) begin
          expq.push_back('{cyc, e.rd, e.d});
          m_clr   = e.rd;
          m_clr_v = 1'b1;
        end
      end else if (wbA_valid_i) begin
        if (wbA_rd_i != '0) expq.push_back('{cyc, wbA_rd_i, wbA_data_i});
        if (nonempty) lost++;
      end
      m_stall = (lost >= LIMIT);
      if (acc) mq.push_back('{mdu_rd_i, mdu_data_i});
      m_ready = (mq.size() < DEPTH);
    end
  end

  // Monitor: compares DUT outputs shortly after each edge
  always @(posedge clk) begin
    bit  exp_we;
    wr_t w;
    #1;
    exp_we = (expq.size() > 0) && (expq[0].stamp == cyc);
    chk("we3", 64'(WE3_o), 64'(exp_we));
    if (exp_we) begin
      w = expq.pop_front();
      if (WE3_o) begin
        chk("ad3", 64'(AD3_o), 64'(w.rd));
        chk("wd3", 64'(WD3_o), 64'(w.d));
      end
    end
    chk("ready", 64'(mdu_ready_o), 64'(m_ready));
    chk("stall", 64'(stall_o), 64'(m_stall));
    chk("hazard", 64'(hazard_o), 64'(m_pend[rs1_i] | m_pend[rs2_i] | m_pend[rd_chk_i]));
  end

  task automatic step(input int av, input int ard, input logic [31:0] ad,
                      input int mv, input int mrd, input logic [31:0] md,
                      input int iv, input int ird, input int s1);
    wbA_valid_i   = (av != 0);
    wbA_rd_i      = AW'(ard);
    wbA_data_i    = ad;
    mdu_valid_i   = (mv != 0);
    mdu_rd_i      = AW'(mrd);
    mdu_data_i    = md;
    issue_valid_i = (iv != 0);
    issue_rd_i    = AW'(ird);
    rs1_i         = AW'(s1);
    rs2_i         = '0;
    rd_chk_i      = '0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Port A only, including a write to register 0
    step(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    step(1, 0, 32'h00000055, 0, 0, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Port B with scoreboard tracking of register 7
    step(0, 0, 0, 0, 0, 0, 1, 7, 7);
    step(0, 0, 0, 1, 7, 32'h12345678, 0, 0, 7);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, 7);

    // Full FIFO under continuous port A, then starvation and forced pop
    for (int i = 0; i < 12; i++)
      step(1, i % 8, 32'hA000 + 32'(i), (i < 3) ? 1 : 0, 10 + i, 32'hB000 + 32'(i), 0, 0, 0);
    step(0, 0, 0, 1, 12, 32'hB002, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Issue of register 9 on the same edge as its port-B commit
    step(0, 0, 0, 0, 0, 0, 1, 9, 9);
    step(0, 0, 0, 1, 9, 32'h99, 0, 0, 9);
    step(0, 0, 0, 0, 0, 0, 0, 0, 9);
    step(0, 0, 0, 0, 0, 0, 1, 9, 9);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 9);

    // Reset mid-stream with two buffered results and register 5 pending
    step(0, 0, 0, 0, 0, 0, 1, 5, 5);
    step(1, 3, 32'h1, 1, 4, 32'h44, 0, 0, 5);
    step(1, 3, 32'h2, 1, 6, 32'h66, 0, 0, 5);
    rst_n = 1'b0;
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 5);
    rst_n = 1'b1;
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 5);

    // Randomized traffic over a small register range
    for (int i = 0; i < 600; i++) begin
      wbA_valid_i   = ($urandom % 3) != 0;
      wbA_rd_i      = AW'($urandom_range(0, 7));
      wbA_data_i    = $urandom;
      mdu_valid_i   = ($urandom % 2) != 0;
      mdu_rd_i      = AW'($urandom_range(0, 7));
      mdu_data_i    = $urandom;
      issue_valid_i = ($urandom % 3) == 0;
      issue_rd_i    = AW'($urandom_range(0, 7));
      rs1_i         = AW'($urandom_range(0, 7));
      rs2_i         = AW'($urandom_range(0, 7));
      rd_chk_i      = AW'($urandom_range(0, 7));
      @(negedge clk);
    end
    repeat (20) step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
